// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: BCD mm:ss stopwatch / countdown timer.
// Advances one step per sec_tick (a clock enable) while running.
// Handles start/stop, clear and BCD load commands with a fixed per-cycle
// priority and drives four registered BCD digits plus run/done status.
module stopwatch_ctrl #(
  parameter int MAX_MIN   = 99,
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sec_tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        mode,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0]  MAX_M10   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_M1    = 4'(MAX_MIN % 10);
  localparam logic [7:0]  MAX_MINS  = {MAX_M10, MAX_M1};
  localparam logic [15:0] BOUND     = {MAX_M10, MAX_M1, 4'd5, 4'd9};

  state_t      state;
  logic        mode_q;
  logic [15:0] next_up;
  logic [15:0] next_dn;
  logic        load_ok;

  // One-step BCD increment with ripple carry through all four digits.
  always_comb begin
    next_up = digits;
    if (digits[3:0] != 4'd9) begin
      next_up[3:0] = digits[3:0] + 4'd1;
    end else begin
      next_up[3:0] = 4'd0;
      if (digits[7:4] != 4'd5) begin
        next_up[7:4] = digits[7:4] + 4'd1;
      end else begin
        next_up[7:4] = 4'd0;
        if (digits[11:8] != 4'd9) begin
          next_up[11:8] = digits[11:8] + 4'd1;
        end else begin
          next_up[11:8]  = 4'd0;
          next_up[15:12] = digits[15:12] + 4'd1;
        end
      end
    end
  end

  // One-step BCD decrement with mirror borrow (0->9, sec10 0->5).
  always_comb begin
    next_dn = digits;
    if (digits[3:0] != 4'd0) begin
      next_dn[3:0] = digits[3:0] - 4'd1;
    end else begin
      next_dn[3:0] = 4'd9;
      if (digits[7:4] != 4'd0) begin
        next_dn[7:4] = digits[7:4] - 4'd1;
      end else begin
        next_dn[7:4] = 4'd5;
        if (digits[11:8] != 4'd0) begin
          next_dn[11:8] = digits[11:8] - 4'd1;
        end else begin
          next_dn[11:8]  = 4'd9;
          next_dn[15:12] = digits[15:12] - 4'd1;
        end
      end
    end
  end

  // A load is acceptable only as proper BCD, seconds below 60, minutes within the ceiling.
  always_comb begin
    load_ok = (load_val[15:12] <= 4'd9) && (load_val[11:8] <= 4'd9) &&
              (load_val[7:4]   <= 4'd5) && (load_val[3:0]  <= 4'd9) &&
              (load_val[15:8]  <= MAX_MINS);
  end

  assign running = (state == RUN);

  // Main controller: one event per cycle in priority order clear > load > start_stop > tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      digits   <= 16'h0000;
      mode_q   <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        digits <= 16'h0000;
      end else if (load) begin
        if (state != RUN) begin
          if (load_ok) begin
            digits <= load_val;
            state  <= PAUSE;
          end else begin
            load_err <= 1'b1;
          end
        end
      end else if (start_stop) begin
        case (state)
          IDLE, PAUSE: begin
            mode_q <= mode;
            if (mode && (digits == 16'h0000)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
          RUN:     state <= PAUSE;
          default: state <= state;
        endcase
      end else if (sec_tick && (state == RUN)) begin
        if (!mode_q) begin
          if (digits == BOUND) begin
            if (AUTO_STOP) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              digits <= 16'h0000;
            end
          end else begin
            digits <= next_up;
            if (AUTO_STOP && (next_up == BOUND)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end else begin
          digits <= next_dn;
          if (next_dn == 16'h0000) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of the stopwatch controller.
// Two instances share the stimulus: u_dut stops at the ceiling, u_wrap wraps.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sec_tick;
  logic        start_stop;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic        mode;
  logic [15:0] digits,  digits_w;
  logic        running, running_w;
  logic        done,    done_w;
  logic        load_err, load_err_w;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.MAX_MIN(99), .AUTO_STOP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .start_stop(start_stop),
    .clear(clear), .load(load), .load_val(load_val), .mode(mode),
    .digits(digits), .running(running), .done(done), .load_err(load_err)
  );

  stopwatch_ctrl #(.MAX_MIN(99), .AUTO_STOP(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .start_stop(start_stop),
    .clear(clear), .load(load), .load_val(load_val), .mode(mode),
    .digits(digits_w), .running(running_w), .done(done_w), .load_err(load_err_w)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Advance one edge and settle past it before sampling
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v; load = 1'b1; cycle(); load = 1'b0;
  endtask

  task automatic do_start();
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
  endtask

  task automatic do_tick();
    sec_tick = 1'b1; cycle(); sec_tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cycle();
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL rst_digits got %h exp 0000", digits); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL rst_running got %b exp 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b exp 0", done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_load_err got %b exp 0", load_err); end
    rst_n = 1'b1;
    do_load(16'h1234);
    do_start();
    do_tick();
    checks++; if (digits !== 16'h1235) begin errors++; $display("[TB] FAIL pre_rst_count got %h exp 1235", digits); end
    rst_n = 1'b0; sec_tick = 1'b1; cycle(); sec_tick = 1'b0;
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL midrun_rst_digits got %h exp 0000", digits); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL midrun_rst_running got %b exp 0", running); end
    rst_n = 1'b1;
  endtask

  task automatic test_up_carry();
    mode = 1'b0;
    do_load(16'h0958);
    do_start();
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL up_start_running got %b exp 1", running); end
    do_tick();
    checks++; if (digits !== 16'h0959) begin errors++; $display("[TB] FAIL up_tick1 got %h exp 0959", digits); end
    do_tick();
    checks++; if (digits !== 16'h1000) begin errors++; $display("[TB] FAIL up_tick2 got %h exp 1000", digits); end
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL up_tick2_running got %b exp 1", running); end
    do_tick();
    checks++; if (digits !== 16'h1001) begin errors++; $display("[TB] FAIL up_tick3 got %h exp 1001", digits); end
    cycle(); cycle();
    checks++; if (digits !== 16'h1001) begin errors++; $display("[TB] FAIL up_no_tick_hold got %h exp 1001", digits); end
    do_clear();
  endtask

  task automatic test_down_done();
    mode = 1'b1;
    do_load(16'h0002);
    do_start();
    mode = 1'b0;
    do_tick();
    checks++; if (digits !== 16'h0001) begin errors++; $display("[TB] FAIL dn_tick1 got %h exp 0001", digits); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dn_tick1_done got %b exp 0", done); end
    do_tick();
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL dn_tick2 got %h exp 0000", digits); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL dn_done_pulse got %b exp 1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL dn_done_running got %b exp 0", running); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dn_done_width got %b exp 0", done); end
    do_tick();
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL dn_hold_tick got %h exp 0000", digits); end
    do_start();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL dn_ignore_start got %b exp 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dn_ignore_start_done got %b exp 0", done); end
    do_tick();
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL dn_hold_after_start got %h exp 0000", digits); end
    do_clear();
    mode = 1'b1;
    do_start();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL dn_zero_start_done got %b exp 1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL dn_zero_start_running got %b exp 0", running); end
    mode = 1'b0;
    do_clear();
  endtask

  task automatic test_collisions();
    mode = 1'b0;
    do_load(16'h0009);
    do_start();
    do_tick();
    checks++; if (digits !== 16'h0010) begin errors++; $display("[TB] FAIL col_setup got %h exp 0010", digits); end
    start_stop = 1'b1; sec_tick = 1'b1; cycle(); start_stop = 1'b0; sec_tick = 1'b0;
    checks++; if (digits !== 16'h0010) begin errors++; $display("[TB] FAIL col_pause_digits got %h exp 0010", digits); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL col_pause_running got %b exp 0", running); end
    start_stop = 1'b1; sec_tick = 1'b1; cycle(); start_stop = 1'b0; sec_tick = 1'b0;
    checks++; if (digits !== 16'h0010) begin errors++; $display("[TB] FAIL col_resume_digits got %h exp 0010", digits); end
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL col_resume_running got %b exp 1", running); end
    do_tick();
    checks++; if (digits !== 16'h0011) begin errors++; $display("[TB] FAIL col_first_step got %h exp 0011", digits); end
    clear = 1'b1; load = 1'b1; load_val = 16'h0500; cycle(); clear = 1'b0; load = 1'b0;
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL col_clear_load got %h exp 0000", digits); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL col_clear_load_running got %b exp 0", running); end
  endtask

  task automatic test_bad_load();
    do_load(16'h0170);
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_load_err got %b exp 1", load_err); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL bad_load_digits got %h exp 0000", digits); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL bad_load_running got %b exp 0", running); end
    cycle();
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL bad_load_width got %b exp 0", load_err); end
    do_load(16'h00A0);
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_digit_err got %b exp 1", load_err); end
    do_load(16'h9959);
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL max_load_err got %b exp 0", load_err); end
    checks++; if (digits !== 16'h9959) begin errors++; $display("[TB] FAIL max_load_digits got %h exp 9959", digits); end
    do_clear();
    mode = 1'b0;
    do_start();
    do_load(16'h0500);
    checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL run_load_digits got %h exp 0000", digits); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL run_load_err got %b exp 0", load_err); end
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL run_load_running got %b exp 1", running); end
    do_clear();
  endtask

  task automatic test_ceiling();
    mode = 1'b0;
    do_load(16'h9958);
    do_start();
    do_tick();
    checks++; if (digits !== 16'h9959) begin errors++; $display("[TB] FAIL ceil_digits got %h exp 9959", digits); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ceil_done got %b exp 1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL ceil_running got %b exp 0", running); end
    checks++; if (digits_w !== 16'h9959) begin errors++; $display("[TB] FAIL wrap_pre_digits got %h exp 9959", digits_w); end
    checks++; if (done_w !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pre_done got %b exp 0", done_w); end
    do_tick();
    checks++; if (digits !== 16'h9959) begin errors++; $display("[TB] FAIL ceil_hold got %h exp 9959", digits); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ceil_done_width got %b exp 0", done); end
    checks++; if (digits_w !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_digits got %h exp 0000", digits_w); end
    checks++; if (running_w !== 1'b1) begin errors++; $display("[TB] FAIL wrap_running got %b exp 1", running_w); end
    checks++; if (done_w !== 1'b0) begin errors++; $display("[TB] FAIL wrap_done got %b exp 0", done_w); end
    checks++; if (load_err_w !== 1'b0) begin errors++; $display("[TB] FAIL wrap_load_err got %b exp 0", load_err_w); end
  endtask

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
    load = 1'b0; load_val = 16'h0000; mode = 1'b0;
    test_reset();
    test_up_carry();
    test_down_done();
    test_collisions();
    test_bad_load();
    test_ceiling();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
